// File: rtl/bird_motion_pkg.sv
// bird_motion_pkg: shared state encoding and physics constants for the bird sprite engine.
package bird_motion_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLY       = 2'd1,
        DEAD_FALL = 2'd2,
        GROUNDED  = 2'd3
    } state_t;
    localparam int                 FRAC_BITS    = 2;
    localparam logic        [8:0]  START_HEIGHT = 9'd200;
    localparam logic        [8:0]  GROUND_Y     = 9'd400;
    localparam logic signed [7:0]  GRAVITY      = 8'sd2;
    localparam logic signed [7:0]  FLAP_VEL     = -8'sd24;
    localparam logic signed [7:0]  MAX_FALL_VEL = 8'sd32;
    localparam logic        [3:0]  ANGLE_LEVEL  = 4'd5;
    localparam logic        [3:0]  ANGLE_MAX    = 4'd10;
endpackage

// File: rtl/bird_angle_map.sv
// bird_angle_map: maps signed quarter-pixel velocity to a 0..10 sprite angle index.
module bird_angle_map
    import bird_motion_pkg::*;
(
    input  logic signed [7:0] i_vel,
    output logic        [3:0] o_angle
);
    logic signed [8:0] w_sum;
    logic signed [8:0] w_idx;
    always_comb begin
        w_sum   = {i_vel[7], i_vel} + 9'sd24;
        w_idx   = w_sum >>> FRAC_BITS;
        o_angle = (w_idx < 9'sd0) ? 4'd0 : (w_idx > 9'sd10) ? ANGLE_MAX : w_idx[3:0];
    end
endmodule

// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: per-frame flap/gravity integrator with ceiling/ground clamps and
// idle/fly/dead-fall/grounded sequencing for the bird sprite.
module bird_motion_ctrl
    import bird_motion_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_tick,
    input  logic       i_flap,
    input  logic       i_collide,
    input  logic       i_restart,
    output logic [8:0] o_bird_height,
    output logic [3:0] o_bird_angle,
    output logic       o_bird_valid,
    output logic       o_bird_dead,
    output logic       o_ground_hit
);
    localparam logic        [10:0] START_POS = 11'(START_HEIGHT) << FRAC_BITS;
    localparam logic        [10:0] GROUND_POS = 11'(GROUND_Y) << FRAC_BITS;
    localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y) << FRAC_BITS;

    state_t            r_state;
    logic       [10:0] r_pos;
    logic signed [7:0] r_vel;
    logic              r_flap_pending;

    state_t            w_state_n;
    logic       [10:0] w_pos_n;
    logic signed [7:0] w_vel_n;
    logic              w_fp_n;
    logic              w_hit_n;
    logic              w_moving;
    logic              w_hit_now;
    logic              w_fp_eff;
    logic signed [7:0] w_vel_in;
    logic signed [8:0] w_vinc;
    logic signed [7:0] w_vgrav;
    logic signed [7:0] w_vnew;
    logic signed [11:0] w_sum;
    logic        [3:0] w_map;
    logic        [3:0] w_angle_n;

    // A collision zeroes velocity before any same-cycle tick, so that tick is a pure dead-fall step.
    always_comb begin
        w_moving  = (r_state == FLY) || (r_state == DEAD_FALL);
        w_hit_now = (r_state == FLY) && i_collide;
        w_vel_in  = w_hit_now ? 8'sd0 : r_vel;
        w_fp_eff  = (r_state == FLY) && !i_collide && (r_flap_pending || i_flap);
        w_vinc    = {w_vel_in[7], w_vel_in} + {GRAVITY[7], GRAVITY};
        w_vgrav   = (w_vinc > 9'sd32) ? MAX_FALL_VEL : w_vinc[7:0];
        w_vnew    = w_fp_eff ? FLAP_VEL : w_vgrav;
        w_sum     = $signed({1'b0, r_pos}) + {{4{w_vnew[7]}}, w_vnew};
        w_state_n = r_state;
        w_pos_n   = r_pos;
        w_vel_n   = r_vel;
        w_fp_n    = r_flap_pending;
        w_hit_n   = 1'b0;
        if (i_restart) begin
            w_state_n = IDLE;
            w_pos_n   = START_POS;
            w_vel_n   = 8'sd0;
            w_fp_n    = 1'b0;
        end else if (r_state == IDLE) begin
            if (i_flap) begin
                w_state_n = FLY;
                w_fp_n    = 1'b1;
            end
        end else if (w_moving) begin
            if (w_hit_now) begin
                w_state_n = DEAD_FALL;
                w_vel_n   = 8'sd0;
                w_fp_n    = 1'b0;
            end else if (r_state == FLY && i_flap) begin
                w_fp_n = 1'b1;
            end
            if (i_frame_tick) begin
                w_fp_n = 1'b0;
                if (w_sum < 12'sd0) begin
                    w_pos_n = 11'd0;
                    w_vel_n = 8'sd0;
                end else if (w_sum >= GROUND_S) begin
                    w_pos_n   = GROUND_POS;
                    w_vel_n   = 8'sd0;
                    w_state_n = GROUNDED;
                    w_hit_n   = 1'b1;
                end else begin
                    w_pos_n = w_sum[10:0];
                    w_vel_n = w_vnew;
                end
            end
        end
        w_angle_n = (w_state_n == IDLE) ? ANGLE_LEVEL : (w_state_n == GROUNDED) ? ANGLE_MAX : w_map;
    end

    bird_angle_map u_angle_map (
        .i_vel   (w_vel_n),
        .o_angle (w_map)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pos          <= START_POS;
            r_vel          <= 8'sd0;
            r_flap_pending <= 1'b0;
            o_bird_angle   <= ANGLE_LEVEL;
            o_bird_valid   <= 1'b1;
            o_bird_dead    <= 1'b0;
            o_ground_hit   <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_pos          <= w_pos_n;
            r_vel          <= w_vel_n;
            r_flap_pending <= w_fp_n;
            o_bird_angle   <= w_angle_n;
            o_bird_valid   <= 1'b1;
            o_bird_dead    <= (w_state_n == DEAD_FALL) || (w_state_n == GROUNDED);
            o_ground_hit   <= w_hit_n;
        end
    end

    assign o_bird_height = r_pos[10:FRAC_BITS];
endmodule
